// File: rtl/m_imem_loader.sv
// UART (8N1) boot loader: receives a word-count header plus big-endian words
// and streams them into the instruction memory while holding the CPU in reset.
module m_imem_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int MAX_WORDS    = 4096
) (
  input  logic        w_clk,
  input  logic        w_rst,
  input  logic        w_rxd,
  output logic        r_we,
  output logic [11:0] r_addr,
  output logic [31:0] r_data,
  output logic        r_proc_rst,
  output logic        r_done,
  output logic        r_err
);

  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] MAX_N   = 16'(MAX_WORDS);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {LD_HDR_HI, LD_HDR_LO, LD_WORD, LD_DONE, LD_ERR} ld_state_t;

  logic        rxd_meta, rxd_sync;

  rx_state_t   rx_state, rx_state_nx;
  logic [15:0] clk_cnt, clk_cnt_nx;
  logic [2:0]  bit_idx, bit_idx_nx;
  logic [7:0]  rx_shift, rx_shift_nx;
  logic        byte_valid, byte_valid_nx;
  logic        frame_err, frame_err_nx;

  ld_state_t   ld_state, ld_state_nx;
  logic [15:0] count, count_nx;
  logic [15:0] hdr_word;
  logic [31:0] word_buf, word_buf_nx;
  logic [1:0]  byte_idx, byte_idx_nx;
  logic [11:0] word_idx, word_idx_nx;
  logic        we_nx, done_nx, err_nx;
  logic [11:0] addr_nx;
  logic [31:0] data_nx;

  assign hdr_word = {count[15:8], rx_shift};

  // Receiver: byte_valid / frame_err are registered one-cycle pulses, rx_shift holds the byte
  always_comb begin
    rx_state_nx   = rx_state;
    clk_cnt_nx    = clk_cnt;
    bit_idx_nx    = bit_idx;
    rx_shift_nx   = rx_shift;
    byte_valid_nx = 1'b0;
    frame_err_nx  = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (!rxd_sync) begin
          rx_state_nx = RX_START;
          clk_cnt_nx  = 16'd0;
        end
      end
      RX_START: begin
        if (clk_cnt == HALF_M1) begin
          clk_cnt_nx  = 16'd0;
          bit_idx_nx  = 3'd0;
          rx_state_nx = rxd_sync ? RX_IDLE : RX_DATA;
        end else begin
          clk_cnt_nx = clk_cnt + 16'd1;
        end
      end
      RX_DATA: begin
        if (clk_cnt == FULL_M1) begin
          clk_cnt_nx  = 16'd0;
          rx_shift_nx = {rxd_sync, rx_shift[7:1]};
          bit_idx_nx  = bit_idx + 3'd1;
          if (bit_idx == 3'd7) rx_state_nx = RX_STOP;
        end else begin
          clk_cnt_nx = clk_cnt + 16'd1;
        end
      end
      RX_STOP: begin
        if (clk_cnt == FULL_M1) begin
          clk_cnt_nx    = 16'd0;
          rx_state_nx   = RX_IDLE;
          byte_valid_nx = rxd_sync;
          frame_err_nx  = !rxd_sync;
        end else begin
          clk_cnt_nx = clk_cnt + 16'd1;
        end
      end
      default: rx_state_nx = RX_IDLE;
    endcase
  end

  always_comb begin
    ld_state_nx = ld_state;
    count_nx    = count;
    word_buf_nx = word_buf;
    byte_idx_nx = byte_idx;
    word_idx_nx = word_idx;
    we_nx       = 1'b0;
    addr_nx     = r_addr;
    data_nx     = r_data;
    case (ld_state)
      LD_HDR_HI: begin
        if (frame_err) begin
          ld_state_nx = LD_ERR;
        end else if (byte_valid) begin
          count_nx    = {rx_shift, 8'h00};
          ld_state_nx = LD_HDR_LO;
        end
      end
      LD_HDR_LO: begin
        if (frame_err) begin
          ld_state_nx = LD_ERR;
        end else if (byte_valid) begin
          count_nx = hdr_word;
          if (hdr_word == 16'd0)     ld_state_nx = LD_DONE;
          else if (hdr_word > MAX_N) ld_state_nx = LD_ERR;
          else                       ld_state_nx = LD_WORD;
        end
      end
      LD_WORD: begin
        if (frame_err) begin
          ld_state_nx = LD_ERR;
        end else if (byte_valid) begin
          word_buf_nx = {word_buf[23:0], rx_shift};
          byte_idx_nx = byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            we_nx   = 1'b1;
            addr_nx = word_idx;
            data_nx = {word_buf[23:0], rx_shift};
            // Stop on the last word instead of incrementing so the index never wraps
            if ({4'b0, word_idx} == count - 16'd1) ld_state_nx = LD_DONE;
            else                                   word_idx_nx = word_idx + 12'd1;
          end
        end
      end
      LD_DONE, LD_ERR: ;
      default: ld_state_nx = LD_HDR_HI;
    endcase
    // Done is held off while the final write is on the port so it appears one cycle later
    done_nx = (ld_state_nx == LD_DONE) && !we_nx;
    err_nx  = (ld_state_nx == LD_ERR);
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      rxd_meta   <= 1'b1;
      rxd_sync   <= 1'b1;
      rx_state   <= RX_IDLE;
      clk_cnt    <= 16'd0;
      bit_idx    <= 3'd0;
      rx_shift   <= 8'd0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      ld_state   <= LD_HDR_HI;
      count      <= 16'd0;
      word_buf   <= 32'd0;
      byte_idx   <= 2'd0;
      word_idx   <= 12'd0;
      r_we       <= 1'b0;
      r_addr     <= 12'd0;
      r_data     <= 32'd0;
      r_proc_rst <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      rxd_meta   <= w_rxd;
      rxd_sync   <= rxd_meta;
      rx_state   <= rx_state_nx;
      clk_cnt    <= clk_cnt_nx;
      bit_idx    <= bit_idx_nx;
      rx_shift   <= rx_shift_nx;
      byte_valid <= byte_valid_nx;
      frame_err  <= frame_err_nx;
      ld_state   <= ld_state_nx;
      count      <= count_nx;
      word_buf   <= word_buf_nx;
      byte_idx   <= byte_idx_nx;
      word_idx   <= word_idx_nx;
      r_we       <= we_nx;
      r_addr     <= addr_nx;
      r_data     <= data_nx;
      r_proc_rst <= !done_nx;
      r_done     <= done_nx;
      r_err      <= err_nx;
    end
  end

endmodule

// File: tb/tb_m_imem_loader.sv
// Scoreboard bench for m_imem_loader: serialises byte images onto w_rxd and
// checks every memory write plus the final done/err status against a model.
module tb_m_imem_loader;

  localparam int CPB  = 4;
  localparam int MAXW = 4096;

  typedef logic [7:0] img_t[$];

  logic        w_clk = 1'b0;
  logic        w_rst = 1'b1;
  logic        w_rxd = 1'b1;
  logic        r_we;
  logic [11:0] r_addr;
  logic [31:0] r_data;
  logic        r_proc_rst;
  logic        r_done;
  logic        r_err;

  m_imem_loader #(.CLKS_PER_BIT(CPB), .MAX_WORDS(MAXW)) dut (
    .w_clk      (w_clk),
    .w_rst      (w_rst),
    .w_rxd      (w_rxd),
    .r_we       (r_we),
    .r_addr     (r_addr),
    .r_data     (r_data),
    .r_proc_rst (r_proc_rst),
    .r_done     (r_done),
    .r_err      (r_err)
  );

  always #5 w_clk = ~w_clk;

  logic [43:0] exp_q[$];
  int  checks = 0;
  int  passed = 0;
  int  we_count = 0;
  int  exp_writes = 0;
  bit  exp_done = 1'b0;
  bit  exp_err = 1'b0;
  bit  done_check_pending = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Monitor: pops the scoreboard on every write and checks completion timing
  always @(negedge w_clk) begin
    logic [43:0] e;
    if (done_check_pending) begin
      done_check_pending = 1'b0;
      checkOutput("done_after_last_we", 32'(r_done), 32'd1);
      checkOutput("proc_rst_after_last_we", 32'(r_proc_rst), 32'd0);
    end
    if (r_we === 1'b1) begin
      we_count++;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_we", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("we_addr", 32'(r_addr), 32'(e[43:32]));
        checkOutput("we_data", r_data, e[31:0]);
        if (exp_q.size() == 0 && exp_done) done_check_pending = 1'b1;
      end
    end
  end

  // Reference: outcome derived from the image format rules alone
  task automatic modelImage(input img_t img, input int err_idx);
    int n, total, nw;
    n     = (img.size() >= 2) ? int'({img[0], img[1]}) : 0;
    total = 2 + 4 * n;
    if (err_idx >= 0 && err_idx < 2)           begin exp_err = 1'b1; nw = 0; end
    else if (n > MAXW)                         begin exp_err = 1'b1; nw = 0; end
    else if (err_idx >= 0 && err_idx < total)  begin exp_err = 1'b1; nw = (err_idx - 2) / 4; end
    else                                       begin exp_err = 1'b0; nw = n; end
    exp_done   = !exp_err;
    exp_writes = nw;
    for (int k = 0; k < nw; k++)
      exp_q.push_back({12'(k), img[2+4*k], img[3+4*k], img[4+4*k], img[5+4*k]});
  endtask

  task automatic sendByte(input logic [7:0] b, input logic stop_bit);
    @(negedge w_clk) w_rxd = 1'b0;
    repeat (CPB - 1) @(negedge w_clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge w_clk) w_rxd = b[i];
      repeat (CPB - 1) @(negedge w_clk);
    end
    @(negedge w_clk) w_rxd = stop_bit;
    repeat (CPB - 1) @(negedge w_clk);
    @(negedge w_clk) w_rxd = 1'b1;
    repeat (stop_bit ? 1 : 12) @(negedge w_clk);
  endtask

  task automatic applyStimulus(input img_t img, input int err_idx);
    for (int i = 0; i < img.size(); i++) begin
      sendByte(img[i], (i == err_idx) ? 1'b0 : 1'b1);
      repeat ($urandom_range(0, 6)) @(negedge w_clk);
    end
  endtask

  task automatic applyReset();
    w_rst = 1'b1;
    w_rxd = 1'b1;
    repeat (3) @(negedge w_clk);
    checkOutput("rst_proc_rst", 32'(r_proc_rst), 32'd1);
    checkOutput("rst_we", 32'(r_we), 32'd0);
    checkOutput("rst_done", 32'(r_done), 32'd0);
    checkOutput("rst_err", 32'(r_err), 32'd0);
    checkOutput("rst_addr", 32'(r_addr), 32'd0);
    checkOutput("rst_data", r_data, 32'd0);
    w_rst = 1'b0;
    done_check_pending = 1'b0;
    we_count = 0;
  endtask

  task automatic runImage(input img_t img, input int err_idx);
    bit ended;
    modelImage(img, err_idx);
    we_count = 0;
    applyStimulus(img, err_idx);
    ended = 1'b0;
    for (int i = 0; i < 400 && !ended; i++) begin
      @(negedge w_clk);
      if (r_done || r_err) ended = 1'b1;
    end
    if (!ended) checkOutput("end_timeout", 32'd0, 32'd1);
    repeat (4) @(negedge w_clk);
    checkOutput("write_count", 32'(we_count), 32'(exp_writes));
    checkOutput("pending_writes", 32'(exp_q.size()), 32'd0);
    checkOutput("final_done", 32'(r_done), 32'(exp_done));
    checkOutput("final_err", 32'(r_err), 32'(exp_err));
    checkOutput("final_proc_rst", 32'(r_proc_rst), 32'(!exp_done));
    checkOutput("done_err_exclusive", 32'(r_done & r_err), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    img_t img;
    int   n, err_idx;

    applyReset();

    img = '{8'h00, 8'h02, 8'h20, 8'h14, 8'h00, 8'h00, 8'h8C, 8'h0B, 8'h00, 8'h00, 8'hAA, 8'h55, 8'h13};
    runImage(img, 12);

    applyReset();
    img = '{8'h00, 8'h00, 8'h37, 8'h00, 8'h00, 8'h01};
    runImage(img, -1);

    applyReset();
    img = '{8'h10, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
    runImage(img, -1);

    applyReset();
    img = '{8'h00, 8'h03, 8'h11};
    runImage(img, 2);

    applyReset();
    @(negedge w_clk) w_rxd = 1'b0;
    @(negedge w_clk) w_rxd = 1'b1;
    repeat (20) @(negedge w_clk);
    checkOutput("glitch_no_we", 32'(we_count), 32'd0);
    checkOutput("glitch_no_err", 32'(r_err), 32'd0);
    img = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    runImage(img, -1);

    applyReset();
    img = '{8'h00, 8'h02, 8'h12, 8'h34};
    applyStimulus(img, -1);
    repeat (5) @(negedge w_clk);
    applyReset();
    img = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h20};
    runImage(img, -1);

    for (int it = 0; it < 10; it++) begin
      applyReset();
      img.delete();
      if ($urandom_range(0, 4) == 0) begin
        n = $urandom_range(MAXW + 1, 65535);
        img.push_back(8'(n >> 8));
        img.push_back(8'(n));
        img.push_back(8'($urandom));
      end else begin
        n = $urandom_range(0, 5);
        img.push_back(8'(n >> 8));
        img.push_back(8'(n));
        for (int k = 0; k < 4 * n + int'($urandom_range(0, 2)); k++) img.push_back(8'($urandom));
      end
      err_idx = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, img.size() - 1)) : -1;
      runImage(img, err_idx);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
